vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_sync_gen.sv | 69 ++++++
 rtl/vga_ctrl.sv | 105 ++++++++++
 tb/tb_vga_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, counter/port widths and the
// colour-bar helper shared by the VGA controller.
package vga_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FRONT_D  = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BACK_D   = 48;
   localparam int H_TOTAL_D  = H_ACTIVE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;

   localparam int V_ACTIVE_D = 480;
   localparam int V_FRONT_D  = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BACK_D   = 33;
   localparam int V_TOTAL_D  = V_ACTIVE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

   localparam int H_CNT_W = 10;
   localparam int V_CNT_W = 10;
   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int RGB_W   = 24;

   // Bar index bit k drives one full colour channel: {R,G,B} = {b2,b1,b0}.
   function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] b);
      return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running pixel/line counters and the combinational
// active / hsync / vsync / frame-start decode of the current count.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FRONT  = H_FRONT_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BACK   = H_BACK_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FRONT  = V_FRONT_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BACK   = V_BACK_D
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic [H_CNT_W-1:0] o_h_cnt,
   output logic [V_CNT_W-1:0] o_v_cnt,
   output logic               o_active,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_frame
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Thresholds sized to the counters so every compare is full width.
   localparam logic [H_CNT_W-1:0] H_LAST  = H_CNT_W'(H_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] H_ACT_C = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] H_SS    = H_CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [H_CNT_W-1:0] H_SE    = H_CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [V_CNT_W-1:0] V_LAST  = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_ACT_C = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] V_SS    = V_CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [V_CNT_W-1:0] V_SE    = V_CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

   // Next count: h wraps at end of line, v steps on each h wrap.
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Counter registers; reset restarts the frame at (0,0).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign o_h_cnt  = h_cnt_q;
   assign o_v_cnt  = v_cnt_q;
   assign o_active = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign o_hsync  = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
   assign o_vsync  = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
   assign o_frame  = (h_cnt_q == '0) && (v_cnt_q == V_ACT_C);

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing controller. Presents pixel coordinates to a
// combinational frame source and registers colour, blank and syncs in one
// stage so all pins stay aligned. Optional macro VGA_TEST_PATTERN_EN
// replaces the frame source with 8 vertical colour bars.
module vga_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FRONT  = H_FRONT_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BACK   = H_BACK_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FRONT  = V_FRONT_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BACK   = V_BACK_D
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic [X_W-1:0]   o_x,
   output logic [Y_W-1:0]   o_y,
   input  logic [RGB_W-1:0] i_rgb,
   output logic [7:0]       o_vga_r,
   output logic [7:0]       o_vga_g,
   output logic [7:0]       o_vga_b,
   output logic             o_hsync_n,
   output logic             o_vsync_n,
   output logic             o_blank_n,
   output logic             o_sync_n,
   output logic             o_frame_start
);

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic               active, hsync, vsync, frame;
   logic [RGB_W-1:0]   pix_rgb;

   vga_sync_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
   ) u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .o_h_cnt  (h_cnt),
      .o_v_cnt  (v_cnt),
      .o_active (active),
      .o_hsync  (hsync),
      .o_vsync  (vsync),
      .o_frame  (frame)
   );

   // Coordinates only mean something inside the visible window.
   assign o_x = active ? X_W'(h_cnt)     : '0;
   assign o_y = active ? v_cnt[Y_W-1:0]  : '0;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [X_W-1:0] BAR_W = X_W'(H_ACTIVE / 8);
   logic [X_W-1:0] bar_idx;
   logic           unused_rgb;
   assign bar_idx    = o_x / BAR_W;
   assign pix_rgb    = bar_colour(bar_idx[2:0]);
   assign unused_rgb = ^{i_rgb, bar_idx[X_W-1:3]};
`else
   assign pix_rgb = i_rgb;
`endif

   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             hs_n_q, hs_n_d, vs_n_q, vs_n_d;
   logic             blank_n_q, blank_n_d, fs_q, fs_d;

   // Output-stage inputs: colour gated to black outside the active area.
   always_comb begin
      rgb_d     = active ? pix_rgb : '0;
      hs_n_d    = ~hsync;
      vs_n_d    = ~vsync;
      blank_n_d = active;
      fs_d      = frame;
   end

   // Single output register: one cycle from counter state to every pin.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rgb_q     <= '0;
         hs_n_q    <= 1'b1;
         vs_n_q    <= 1'b1;
         blank_n_q <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         rgb_q     <= rgb_d;
         hs_n_q    <= hs_n_d;
         vs_n_q    <= vs_n_d;
         blank_n_q <= blank_n_d;
         fs_q      <= fs_d;
      end
   end

   assign o_vga_r       = rgb_q[23:16];
   assign o_vga_g       = rgb_q[15:8];
   assign o_vga_b       = rgb_q[7:0];
   assign o_hsync_n     = hs_n_q;
   assign o_vsync_n     = vs_n_q;
   assign o_blank_n     = blank_n_q;
   assign o_sync_n      = 1'b0;
   assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: reduced-timing bench. A reference model derives every
// expected pin value from the position in the frame (cycles since reset).
module tb_vga_ctrl;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 48, VF = 3, VS = 2, VB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [9:0]  o_x;
   logic [8:0]  o_y;
   logic [23:0] i_rgb;
   logic [7:0]  o_vga_r, o_vga_g, o_vga_b;
   logic        o_hsync_n, o_vsync_n, o_blank_n, o_sync_n, o_frame_start;

   logic [23:0] seed;
   int          n;        // model frame position of the DUT counters
   int          checks = 0;
   int          passes = 0;

   vga_ctrl #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .o_x           (o_x),
      .o_y           (o_y),
      .i_rgb         (i_rgb),
      .o_vga_r       (o_vga_r),
      .o_vga_g       (o_vga_g),
      .o_vga_b       (o_vga_b),
      .o_hsync_n     (o_hsync_n),
      .o_vsync_n     (o_vsync_n),
      .o_blank_n     (o_blank_n),
      .o_sync_n      (o_sync_n),
      .o_frame_start (o_frame_start)
   );

   always #5 clk = ~clk;

   // Frame source: seed 0 gives {x[7:0], y[7:0], 8'hA5}.
   function automatic logic [23:0] src(input logic [9:0] x, input logic [8:0] y,
                                       input logic [23:0] s);
      return {x[7:0] ^ s[23:16], y[7:0] ^ s[15:8], 8'hA5 ^ s[7:0]};
   endfunction

   always_comb i_rgb = src(o_x, o_y, seed);

   logic [27:0] act_o;
   assign act_o = {o_vga_r, o_vga_g, o_vga_b, o_hsync_n, o_vsync_n, o_blank_n, o_frame_start};

   // Expected pins after an edge taken at frame position p: {rgb,hs_n,vs_n,blank_n,fs}.
   function automatic logic [27:0] model(input int p, input logic rst, input logic [23:0] s);
      int h, v;
      logic a;
      logic [23:0] c;
      logic [2:0] b;
      if (rst) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
      h = p % HT;
      v = p / HT;
      a = (h < HA) && (v < VA);
      c = 24'h0;
`ifdef VGA_TEST_PATTERN_EN
      b = 3'(h / (HA / 8));
      if (a) c = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
`else
      b = 3'd0;
      if (a) c = src(10'(h), 9'(v), s);
`endif
      return {c, !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
              a, (h == 0) && (v == VA)};
   endfunction

   function automatic logic [18:0] model_xy(input int p);
      int h, v;
      h = p % HT;
      v = p / HT;
      if (h < HA && v < VA) return {10'(h), 9'(v)};
      return 19'h0;
   endfunction

   task automatic test_reset();
      logic [27:0] ex;
      i_rst = 1'b1;
      seed  = $urandom;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         i_rst = 1'b1;
         checks++;
         if ({o_x, o_y} !== 19'h0) $display("FAIL reset_xy x=%0d y=%0d want 0/0", o_x, o_y);
         else passes++;
         ex = model(0, 1'b1, seed);
         @(posedge clk); #1;
         checks++;
         if (act_o !== ex) $display("FAIL reset_pins got=%h want=%h", act_o, ex);
         else passes++;
      end
      checks++;
      if (o_sync_n !== 1'b0) $display("FAIL sync_n got=%b want=0", o_sync_n);
      else passes++;
      n = 0;
   endtask

   task automatic test_first_pixel();
      logic [27:0] ex;
      @(negedge clk);
      i_rst = 1'b0;
      ex = model(0, 1'b0, seed);
      @(posedge clk); #1;
      checks++;
      if (act_o !== ex || o_blank_n !== 1'b1)
         $display("FAIL first_pixel got=%h want=%h", act_o, ex);
      else passes++;
      checks++;
      if (o_x !== 10'd1 || o_y !== 9'd0) $display("FAIL first_advance x=%0d y=%0d want 1/0", o_x, o_y);
      else passes++;
      n = 1;
   endtask

   // Two full frames from reset with aggregate timing statistics per frame.
   task automatic test_frame();
      logic [27:0] ex;
      int hrun, vrun, hwin, vwin, blanks, fscnt, fspos, lastfall, maxx, maxy;
      i_rst = 1'b1;
      @(posedge clk); #1;
      n = 0;
      for (int f = 0; f < 2; f++) begin
         seed = (f == 0) ? 24'h0 : 24'($urandom);
         hrun = 0; vrun = 0; hwin = 0; vwin = 0; blanks = 0;
         fscnt = 0; fspos = -1; lastfall = -1; maxx = 0; maxy = 0;
         for (int k = 0; k < FT; k++) begin
            @(negedge clk);
            i_rst = 1'b0;
            checks++;
            if ({o_x, o_y} !== model_xy(n)) $display("FAIL frame_xy n=%0d got=%0d/%0d", n, o_x, o_y);
            else passes++;
            if (int'(o_x) > maxx) maxx = int'(o_x);
            if (int'(o_y) > maxy) maxy = int'(o_y);
            ex = model(n, 1'b0, seed);
            @(posedge clk); #1;
            checks++;
            if (act_o !== ex) $display("FAIL frame_pins n=%0d got=%h want=%h", n, act_o, ex);
            else passes++;
            n = (n + 1) % FT;
            if (!o_hsync_n) begin
               if (hrun == 0) begin
                  if (lastfall >= 0) begin
                     checks++;
                     if (k - lastfall !== HT) $display("FAIL line_period got=%0d want=%0d", k - lastfall, HT);
                     else passes++;
                  end
                  lastfall = k;
               end
               hrun++;
            end else if (hrun > 0) begin
               hwin++;
               checks++;
               if (hrun !== HS) $display("FAIL hsync_width got=%0d want=%0d", hrun, HS);
               else passes++;
               hrun = 0;
            end
            if (!o_vsync_n) vrun++;
            else if (vrun > 0) begin
               vwin++;
               checks++;
               if (vrun !== VS * HT) $display("FAIL vsync_width got=%0d want=%0d", vrun, VS * HT);
               else passes++;
               vrun = 0;
            end
            if (o_blank_n) blanks++;
            if (o_frame_start) begin fscnt++; fspos = k; end
         end
         checks++;
         if (hwin !== VT || vwin !== 1) $display("FAIL sync_windows h=%0d v=%0d want %0d/1", hwin, vwin, VT);
         else passes++;
         checks++;
         if (blanks !== HA * VA) $display("FAIL blank_count got=%0d want=%0d", blanks, HA * VA);
         else passes++;
         checks++;
         if (fscnt !== 1 || fspos !== VA * HT)
            $display("FAIL frame_start cnt=%0d pos=%0d want 1/%0d", fscnt, fspos, VA * HT);
         else passes++;
         checks++;
         if (maxx !== HA - 1 || maxy !== VA - 1)
            $display("FAIL xy_max got=%0d/%0d want %0d/%0d", maxx, maxy, HA - 1, VA - 1);
         else passes++;
      end
   endtask

   // Reset landing inside vsync must kill both syncs on the very next edge.
   task automatic test_reset_midframe();
      logic [27:0] ex;
      int target, guard;
      target = (VA + VF + 1) * HT + int'($urandom_range(HT - 1));
      guard  = 0;
      while (n != target && guard < 2 * FT) begin
         @(negedge clk);
         i_rst = 1'b0;
         ex = model(n, 1'b0, seed);
         @(posedge clk); #1;
         checks++;
         if (act_o !== ex) $display("FAIL mid_run n=%0d got=%h want=%h", n, act_o, ex);
         else passes++;
         n = (n + 1) % FT;
         guard++;
      end
      checks++;
      if (n != target) $display("FAIL mid_reach n=%0d want=%0d", n, target);
      else passes++;
      @(negedge clk);
      i_rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({o_hsync_n, o_vsync_n, o_blank_n, o_frame_start} !== 4'b1100 || act_o[27:4] !== 24'h0)
         $display("FAIL mid_reset got=%h want=%h", act_o, model(0, 1'b1, seed));
      else passes++;
      n = 0;
      for (int k = 0; k < 2 * HT; k++) begin
         @(negedge clk);
         i_rst = 1'b0;
         checks++;
         if ({o_x, o_y} !== model_xy(n)) $display("FAIL restart_xy n=%0d got=%0d/%0d", n, o_x, o_y);
         else passes++;
         ex = model(n, 1'b0, seed);
         @(posedge clk); #1;
         checks++;
         if (act_o !== ex) $display("FAIL restart_pins n=%0d got=%h want=%h", n, act_o, ex);
         else passes++;
         n = (n + 1) % FT;
      end
   endtask

   // Random run lengths, random reset pulses and a fresh source seed per burst.
   task automatic test_back_to_back();
      logic [27:0] ex;
      logic r;
      int len, rlen;
      for (int s = 0; s < 24; s++) begin
         len  = int'($urandom_range(600, 1));
         rlen = int'($urandom_range(3, 0));
         for (int k = 0; k < len + rlen; k++) begin
            @(negedge clk);
            r = (k >= len);
            i_rst = r;
            if (k == 0) seed = $urandom;
            checks++;
            if ({o_x, o_y} !== model_xy(n)) $display("FAIL b2b_xy n=%0d got=%0d/%0d", n, o_x, o_y);
            else passes++;
            ex = model(n, r, seed);
            @(posedge clk); #1;
            checks++;
            if (act_o !== ex) $display("FAIL b2b_pins n=%0d rst=%b got=%h want=%h", n, r, act_o, ex);
            else passes++;
            n = r ? 0 : (n + 1) % FT;
         end
      end
   endtask

`ifdef VGA_TEST_PATTERN_EN
   // Pixel in bar 5 of line 0 must be magenta regardless of the source.
   task automatic test_pattern();
      int x5, guard;
      x5 = 5 * (HA / 8) + 2;
      seed = 24'h0;
      guard = 0;
      while (n != x5 && guard < 2 * FT) begin
         @(negedge clk);
         i_rst = 1'b0;
         @(posedge clk); #1;
         n = (n + 1) % FT;
         guard++;
      end
      @(negedge clk);
      @(posedge clk); #1;
      n = (n + 1) % FT;
      checks++;
      if ({o_vga_r, o_vga_g, o_vga_b} !== 24'hFF00FF)
         $display("FAIL pattern_bar5 got=%h want=ff00ff", {o_vga_r, o_vga_g, o_vga_b});
      else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_first_pixel();
      test_frame();
      test_reset_midframe();
      test_back_to_back();
`ifdef VGA_TEST_PATTERN_EN
      test_reset();
      test_pattern();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
